rst_seq_ctrl: RTL and testbench

Parametrised reset sequencer and timebase for the 27 MHz system domain. It replaces the single top-level rst_n fan-out with these functions:
- synchronised reset release;
- a programmable hold period;
- staggered per-channel reset release;
- a software-requested re-sequence;
- a 1 µs tick.

It sits directly under top, between the board reset pin and all downstream functional blocks.

---
 rtl/rst_seq_pkg.sv | 22 ++
 rtl/rst_sync_async.sv | 24 ++
 rtl/rst_seq_ctrl.sv | 172 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, default timing values and counter sizing for the
// reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_REL  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam int DEF_HOLD_CYC    = 270;
    localparam int DEF_STAGGER_CYC = 27;
    localparam int DEF_TICK_DIV    = 27;
    localparam int DEF_WDOG_CYC    = 2700000;

    // Bits needed to represent every value in 0..max.
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/rst_sync_async.sv
`timescale 1ns/1ps
// Asynchronous-assert, synchronous-deassert reset synchroniser.
// srst_n rises on the SYNC_STAGES-th clock edge after rst_n goes high.
module rst_sync_async #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic srst_n
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign srst_n = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
`timescale 1ns/1ps
// Reset sequencer (HOLD -> staggered REL -> RUN) plus a free-running 1 us tick.
// Define RST_SEQ_WDOG_EN to build the RUN-state watchdog that forces a re-sequence.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = DEF_HOLD_CYC,
    parameter int STAGGER_CYC = DEF_STAGGER_CYC,
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int WDOG_CYC    = DEF_WDOG_CYC
) (
    input  logic              clk_27M,
    input  logic              rst_n,
    input  logic              soft_rst_req,
    output logic              soft_rst_ack,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              seq_done,
    output logic              tick_1us,
    output logic [1:0]        state_o,
    input  logic              wdog_kick,
    output logic              wdog_fired
);

    localparam int HOLD_W = cnt_w(HOLD_CYC);
    localparam int STAG_W = cnt_w(STAGGER_CYC);
    localparam int TICK_W = cnt_w(TICK_DIV);

    logic              srst_n;
    state_t            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [STAG_W-1:0] stag_q, stag_d;
    logic [NUM_CH-1:0] ch_q, ch_d;
    logic              ack_q, ack_d;
    logic [TICK_W-1:0] tick_cnt_q;
    logic              tick_q;
    logic              wd_expire;

    rst_sync_async #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk_27M),
        .rst_n (rst_n),
        .srst_n(srst_n)
    );

    // srst_n clears asynchronously with rst_n, so every flop below follows
    // the board pin immediately but only leaves reset after synchronisation.
    always_ff @(posedge clk_27M or negedge srst_n) begin
        if (!srst_n) begin
            state_q <= ST_HOLD;
            hold_q  <= '0;
            stag_q  <= '0;
            ch_q    <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            stag_q  <= stag_d;
            ch_q    <= ch_d;
            ack_q   <= ack_d;
        end
    end

    // soft_rst_req is a level request; it is accepted only when sampled in RUN,
    // and acceptance is signalled by a single-cycle soft_rst_ack. Requests seen
    // in HOLD or REL are dropped, not queued.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        stag_d  = stag_q;
        ch_d    = ch_q;
        ack_d   = 1'b0;
        case (state_q)
            ST_HOLD: begin
                ch_d = '0;
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    state_d = ST_REL;
                    hold_d  = '0;
                    stag_d  = '0;
                    ch_d    = NUM_CH'(1);
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            ST_REL: begin
                if (&ch_q) begin
                    state_d = ST_RUN;
                    stag_d  = '0;
                end else if (stag_q == STAG_W'(STAGGER_CYC - 1)) begin
                    ch_d   = (ch_q << 1) | NUM_CH'(1);
                    stag_d = '0;
                end else begin
                    stag_d = stag_q + STAG_W'(1);
                end
            end
            ST_RUN: begin
                if (soft_rst_req || wd_expire) begin
                    ack_d   = soft_rst_req;
                    state_d = ST_HOLD;
                    hold_d  = '0;
                    stag_d  = '0;
                    ch_d    = '0;
                end
            end
            default: begin
                state_d = ST_HOLD;
                hold_d  = '0;
                stag_d  = '0;
                ch_d    = '0;
            end
        endcase
    end

    // Timebase depends only on srst_n so a soft reset keeps the tick phase.
    always_ff @(posedge clk_27M or negedge srst_n) begin
        if (!srst_n) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b0;
        end else if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt_q <= '0;
            tick_q     <= 1'b1;
        end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            tick_q     <= 1'b0;
        end
    end

`ifdef RST_SEQ_WDOG_EN
    localparam int WD_W = cnt_w(WDOG_CYC);

    logic [WD_W-1:0] wd_q;
    logic            wd_fired_q;

    // A kick on the expiry cycle wins; a soft request on that cycle takes
    // precedence and the event is treated as a normal soft reset.
    assign wd_expire = (state_q == ST_RUN) && !wdog_kick &&
                       (wd_q == WD_W'(WDOG_CYC - 1));

    always_ff @(posedge clk_27M or negedge srst_n) begin
        if (!srst_n) begin
            wd_q       <= '0;
            wd_fired_q <= 1'b0;
        end else begin
            if ((state_q != ST_RUN) || wdog_kick || wd_expire) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (wd_expire && !soft_rst_req) begin
                wd_fired_q <= 1'b1;
            end
        end
    end

    assign wdog_fired = wd_fired_q;
`else
    logic unused_wdog;

    assign wd_expire   = 1'b0;
    assign wdog_fired  = 1'b0;
    assign unused_wdog = wdog_kick & (WDOG_CYC != 0);
`endif

    assign ch_rst_n     = ch_q;
    assign seq_done     = (state_q == ST_RUN);
    assign soft_rst_ack = ack_q;
    assign tick_1us     = tick_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for rst_seq_ctrl: power-on, tick, soft reset, held
// request, mid-sequence reset and (with RST_SEQ_WDOG_EN) the watchdog.
module tb_rst_seq_ctrl;

    localparam int NUM_CH = 4;
    localparam int HOLD   = 270;
    localparam int STAG   = 27;
    localparam int TDIV   = 27;
`ifdef RST_SEQ_WDOG_EN
    localparam int WDOG   = 100;
`else
    localparam int WDOG   = 2700000;
`endif

    logic              clk_27M;
    logic              rst_n;
    logic              soft_rst_req;
    logic              wdog_kick;
    logic              soft_rst_ack;
    logic [NUM_CH-1:0] ch_rst_n;
    logic              seq_done;
    logic              tick_1us;
    logic [1:0]        state_o;
    logic              wdog_fired;

    int          checks;
    int          failures;
    int          cyc;
    int          e0;
    int          seq_base;
    logic [31:0] exp_q[$];

    rst_seq_ctrl #(
        .NUM_CH     (NUM_CH),
        .SYNC_STAGES(2),
        .HOLD_CYC   (HOLD),
        .STAGGER_CYC(STAG),
        .TICK_DIV   (TDIV),
        .WDOG_CYC   (WDOG)
    ) dut (
        .clk_27M     (clk_27M),
        .rst_n       (rst_n),
        .soft_rst_req(soft_rst_req),
        .soft_rst_ack(soft_rst_ack),
        .ch_rst_n    (ch_rst_n),
        .seq_done    (seq_done),
        .tick_1us    (tick_1us),
        .state_o     (state_o),
        .wdog_kick   (wdog_kick),
        .wdog_fired  (wdog_fired)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk_27M = 1'b0;
        forever #18.52 clk_27M = ~clk_27M;
    end

    always @(posedge clk_27M) cyc = cyc + 1;

    initial begin
        #2ms;
        $display("FAIL global_timeout got=%0d cycles exp=completion", cyc);
        $fatal(1, "bench stopped");
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            @(negedge clk_27M);
            checks++;
            if ({ch_rst_n, seq_done, soft_rst_ack, tick_1us, wdog_fired, state_o} !== '0) begin
                failures++;
                $display("FAIL reset_outputs got=%b exp=0", {ch_rst_n, seq_done, soft_rst_ack, tick_1us, wdog_fired, state_o});
            end
        end
    endtask

    task automatic test_power_on();
        #(100.0 - $realtime);
        rst_n = 1'b1;
        e0 = cyc + 2;
        for (int n = 0; n < 2; n++) begin
            @(negedge clk_27M);
            checks++;
            if ({ch_rst_n, seq_done, tick_1us, state_o} !== '0) begin
                failures++;
                $display("FAIL pre_release got=%b exp=0", {ch_rst_n, seq_done, tick_1us, state_o});
            end
        end
    endtask

    task automatic test_tick();
        logic [31:0] got, exp;
        real t_prev, t_now;
        int n_seen;
        t_prev = 0.0;
        n_seen = 0;
        for (int k = 1; k <= 3; k++) exp_q.push_back(32'(e0 + k * TDIV));
        for (int n = 0; n < 200 && exp_q.size() > 0; n++) begin
            @(negedge clk_27M);
            if (tick_1us === 1'b1) begin
                got = 32'(cyc);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL tick_cycle got=%0d exp=%0d", got, exp);
                end
                t_now = $realtime;
                if (n_seen > 0) begin
                    checks++;
                    if ((t_now - t_prev) < 962.96 || (t_now - t_prev) > 1037.04) begin
                        failures++;
                        $display("FAIL tick_period got=%f exp=1000+-37.04", t_now - t_prev);
                    end
                end
                t_prev = t_now;
                n_seen++;
                @(negedge clk_27M);
                checks++;
                if (tick_1us !== 1'b0) begin
                    failures++;
                    $display("FAIL tick_width got=%b exp=0", tick_1us);
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL tick_timeout got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Follows one full sequence whose HOLD counter was at 0 after edge 'base'.
    task automatic check_sequence(input string tag, input int base);
        logic [NUM_CH-1:0] prev_ch;
        logic              prev_done;
        logic              exp_tick;
        logic [31:0]       got, exp;
        int                budget;
        for (int k = 0; k < NUM_CH; k++) exp_q.push_back(32'(base + HOLD + k * STAG));
        exp_q.push_back(32'(base + HOLD + (NUM_CH - 1) * STAG + 1));
        prev_ch   = ch_rst_n;
        prev_done = seq_done;
        budget    = base + HOLD + NUM_CH * STAG + 20 - cyc;
        for (int n = 0; n < budget && exp_q.size() > 0; n++) begin
            @(negedge clk_27M);
            got = 32'(cyc);
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_rst_n[k] === 1'b1 && prev_ch[k] !== 1'b1) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                    checks++;
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL %s_ch%0d_rise got=%0d exp=%0d", tag, k, got, exp);
                    end
                    if (k == 0) begin
                        checks++;
                        if (state_o !== 2'd1) begin
                            failures++;
                            $display("FAIL %s_state_rel got=%0d exp=1", tag, state_o);
                        end
                    end
                end
            end
            if (seq_done === 1'b1 && prev_done !== 1'b1) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL %s_done_rise got=%0d exp=%0d", tag, got, exp);
                end
                checks++;
                if (state_o !== 2'd2 || ch_rst_n !== '1) begin
                    failures++;
                    $display("FAIL %s_run_state got=%0d/%b exp=2/1111", tag, state_o, ch_rst_n);
                end
            end
            checks++;
            if ((prev_ch & ~ch_rst_n) !== '0) begin
                failures++;
                $display("FAIL %s_ch_fall got=%b exp=no_fall_from_%b", tag, ch_rst_n, prev_ch);
            end
            checks++;
            if (soft_rst_ack !== 1'b0) begin
                failures++;
                $display("FAIL %s_no_ack got=%b exp=0 cyc=%0d", tag, soft_rst_ack, cyc);
            end
            exp_tick = (cyc > e0) && (((cyc - e0) % TDIV) == 0);
            checks++;
            if (tick_1us !== exp_tick) begin
                failures++;
                $display("FAIL %s_tick got=%b exp=%b cyc=%0d", tag, tick_1us, exp_tick, cyc);
            end
            checks++;
            if (wdog_fired !== 1'b0) begin
                failures++;
                $display("FAIL %s_wdog_quiet got=%b exp=0", tag, wdog_fired);
            end
            prev_ch   = ch_rst_n;
            prev_done = seq_done;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout got=%0d pending exp=0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_soft_reset();
        soft_rst_req = 1'b1;
        @(negedge clk_27M);
        seq_base = cyc;
        checks++;
        if (soft_rst_ack !== 1'b1) begin
            failures++;
            $display("FAIL soft_ack got=%b exp=1", soft_rst_ack);
        end
        checks++;
        if ({ch_rst_n, seq_done, state_o} !== '0) begin
            failures++;
            $display("FAIL soft_clear got=%b exp=0", {ch_rst_n, seq_done, state_o});
        end
        soft_rst_req = 1'b0;
        @(negedge clk_27M);
        checks++;
        if (soft_rst_ack !== 1'b0) begin
            failures++;
            $display("FAIL soft_ack_width got=%b exp=0", soft_rst_ack);
        end
        check_sequence("soft", seq_base);
    endtask

    task automatic test_held_request();
        soft_rst_req = 1'b1;
        @(negedge clk_27M);
        seq_base = cyc;
        checks++;
        if (soft_rst_ack !== 1'b1) begin
            failures++;
            $display("FAIL held_first_ack got=%b exp=1", soft_rst_ack);
        end
        check_sequence("held", seq_base);
        @(negedge clk_27M);
        checks++;
        if (soft_rst_ack !== 1'b1 || {ch_rst_n, state_o} !== '0) begin
            failures++;
            $display("FAIL held_run_ack got=%b/%b exp=1/0", soft_rst_ack, {ch_rst_n, state_o});
        end
        seq_base = cyc;
        soft_rst_req = 1'b0;
        @(negedge clk_27M);
        checks++;
        if (soft_rst_ack !== 1'b0) begin
            failures++;
            $display("FAIL held_single_ack got=%b exp=0", soft_rst_ack);
        end
    endtask

    task automatic test_mid_reset();
        int target;
        target = seq_base + HOLD + STAG + 5;
        for (int n = 0; n < 400 && cyc < target; n++) @(negedge clk_27M);
        checks++;
        if (ch_rst_n !== 4'b0011 || state_o !== 2'd1) begin
            failures++;
            $display("FAIL mid_precondition got=%b/%0d exp=0011/1", ch_rst_n, state_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ch_rst_n, seq_done, soft_rst_ack, tick_1us, wdog_fired, state_o} !== '0) begin
            failures++;
            $display("FAIL mid_async_clear got=%b exp=0", {ch_rst_n, seq_done, soft_rst_ack, tick_1us, wdog_fired, state_o});
        end
        #49;
        rst_n = 1'b1;
        e0 = cyc + 2;
        check_sequence("mid", e0);
    endtask

`ifdef RST_SEQ_WDOG_EN
    task automatic test_wdog();
        int          last_kick;
        logic [31:0] got, exp;
        last_kick = cyc;
        for (int i = 0; i < 6; i++) begin
            wdog_kick = 1'b1;
            last_kick = cyc + 1;
            @(negedge clk_27M);
            wdog_kick = 1'b0;
            for (int n = 0; n < 49; n++) begin
                @(negedge clk_27M);
                checks++;
                if (wdog_fired !== 1'b0 || seq_done !== 1'b1) begin
                    failures++;
                    $display("FAIL wdog_kicked got=%b/%b exp=0/1", wdog_fired, seq_done);
                end
            end
        end
        exp_q.push_back(32'(last_kick + WDOG));
        for (int n = 0; n < WDOG + 20 && exp_q.size() > 0; n++) begin
            @(negedge clk_27M);
            checks++;
            if (soft_rst_ack !== 1'b0) begin
                failures++;
                $display("FAIL wdog_no_ack got=%b exp=0", soft_rst_ack);
            end
            if (wdog_fired === 1'b1) begin
                got = 32'(cyc);
                exp = exp_q.pop_front();
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL wdog_fire_cycle got=%0d exp=%0d", got, exp);
                end
                checks++;
                if ({ch_rst_n, seq_done, state_o} !== '0) begin
                    failures++;
                    $display("FAIL wdog_reset got=%b exp=0", {ch_rst_n, seq_done, state_o});
                end
            end
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL wdog_timeout got=%0d pending exp=0", exp_q.size());
            exp_q.delete();
        end
        repeat (5) @(negedge clk_27M);
        checks++;
        if (wdog_fired !== 1'b1 || soft_rst_ack !== 1'b0) begin
            failures++;
            $display("FAIL wdog_sticky got=%b/%b exp=1/0", wdog_fired, soft_rst_ack);
        end
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        checks       = 0;
        failures     = 0;
        cyc          = 0;
        e0           = 0;
        seq_base     = 0;
        rst_n        = 1'b0;
        soft_rst_req = 1'b0;
        wdog_kick    = 1'b0;
        test_reset();
        test_power_on();
        test_tick();
        check_sequence("por", e0);
        test_soft_reset();
        test_held_request();
        test_mid_reset();
`ifdef RST_SEQ_WDOG_EN
        test_wdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
